bk_chain_seq: RTL and testbench

Multi-precision add sequencer that time-shares one 6-bit `brent_kung_cin` adder to perform wide additions limb by limb. Carry is fed back between limbs. The block sits beside the existing Brent-Kung datapath as its controller. It accepts a wide operand pair on a start strobe, runs one limb per clock through the shared adder, and presents a registered wide sum, carry-out, signed-overflow flag and a one-cycle done pulse. It is intended as a new `ctrl` mode of the top-level mux/demux.

---
 rtl/bk_pkg.sv | 20 ++
 rtl/bk_limb_shreg.sv | 30 +++
 rtl/brent_kung_cin.sv | 54 +++++
 rtl/bk_chain_seq.sv | 137 +++++++++++++
 tb/tb_bk_chain_seq.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/bk_pkg.sv
// Shared types and defaults for the limb-serial Brent-Kung add sequencer.
// Consumers: brent_kung_cin, bk_limb_shreg, bk_chain_seq.
package bk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } bk_state_e;

  localparam int BK_LIMB_W = 6;
  localparam int BK_LIMBS  = 4;
  // Adder result is {spare, carry, sum}.
  localparam int BK_ADD_W  = BK_LIMB_W + 2;

  function automatic int bk_add_w(input int limb_w);
    return limb_w + 2;
  endfunction

endpackage

// File: rtl/bk_limb_shreg.sv
// Wide operand register: parallel load, then shifts down one limb per step.
module bk_limb_shreg
  import bk_pkg::*;
#(
  parameter int LIMBS  = BK_LIMBS,
  parameter int LIMB_W = BK_LIMB_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic                    shift,
  input  logic [LIMBS*LIMB_W-1:0] d,
  output logic [LIMB_W-1:0]       limb
);

  logic [LIMBS*LIMB_W-1:0] q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end else if (shift) begin
      q <= q >> LIMB_W;
    end
  end

  assign limb = q[LIMB_W-1:0];

endmodule

// File: rtl/brent_kung_cin.sv
// W-bit Brent-Kung prefix adder with carry-in; y = {1'b0, carry, sum}.
module brent_kung_cin
  import bk_pkg::*;
#(
  parameter int W = BK_LIMB_W
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W+1:0] y
);

  localparam int L = $clog2(W);
  localparam int S = 2 * L;

  logic [W-1:0] g_s [0:S];
  logic [W-1:0] p_s [0:S];
  logic [W-1:0] carry_in;

  // Carry-in folded into bit 0 so every prefix G[i] is the carry out of bit i.
  assign g_s[0] = (a & b) | {{(W-1){1'b0}}, (a[0] ^ b[0]) & cin};
  assign p_s[0] = a ^ b;

  for (genvar l = 0; l < L; l++) begin : g_up
    localparam int D = 1 << l;
    for (genvar i = 0; i < W; i++) begin : g_bit
      if ((i + 1) % (2 * D) == 0) begin : g_op
        assign g_s[l+1][i] = g_s[l][i] | (p_s[l][i] & g_s[l][i-D]);
        assign p_s[l+1][i] = p_s[l][i] & p_s[l][i-D];
      end else begin : g_pass
        assign g_s[l+1][i] = g_s[l][i];
        assign p_s[l+1][i] = p_s[l][i];
      end
    end
  end

  // Down-sweep fills in the odd-multiple positions the up-sweep skipped.
  for (genvar l = 0; l < L; l++) begin : g_dn
    localparam int D = 1 << (L - 1 - l);
    for (genvar i = 0; i < W; i++) begin : g_bit
      if (((i + 1) % (2 * D) == D) && (i + 1 > D)) begin : g_op
        assign g_s[L+l+1][i] = g_s[L+l][i] | (p_s[L+l][i] & g_s[L+l][i-D]);
        assign p_s[L+l+1][i] = p_s[L+l][i] & p_s[L+l][i-D];
      end else begin : g_pass
        assign g_s[L+l+1][i] = g_s[L+l][i];
        assign p_s[L+l+1][i] = p_s[L+l][i];
      end
    end
  end

  assign carry_in = {g_s[S][W-2:0], cin};
  assign y        = {1'b0, g_s[S][W-1], p_s[0] ^ carry_in};

endmodule

// File: rtl/bk_chain_seq.sv
// Limb-serial wide adder: one shared brent_kung_cin, carry fed back per limb.
// Optional subtract mode (port sub) is built when BK_SUB_EN is defined.
module bk_chain_seq
  import bk_pkg::*;
#(
  parameter int LIMBS  = BK_LIMBS,
  parameter int LIMB_W = BK_LIMB_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [LIMBS*LIMB_W-1:0] op_a,
  input  logic [LIMBS*LIMB_W-1:0] op_b,
  input  logic                    cin,
`ifdef BK_SUB_EN
  input  logic                    sub,
`endif
  output logic                    busy,
  output logic                    done,
  output logic [LIMBS*LIMB_W-1:0] result,
  output logic                    cout,
  output logic                    ovf,
  output bk_state_e               state_dbg
);

  localparam int W     = LIMBS * LIMB_W;
  localparam int IDX_W = $clog2(LIMBS);
  localparam int ADD_W = LIMB_W + 2;

  // Handshake: start is a request taken only while IDLE (busy low); it is
  // dropped otherwise. done is a one-cycle valid for result/cout/ovf; no ready.

  bk_state_e          state_q, state_nxt;
  logic               accept, step, last;
  logic [IDX_W-1:0]   idx_q;
  logic               carry_q;
  logic [W-1:0]       result_q, result_nxt, limb_mask, limb_ins;
  logic               cout_q, ovf_q;
  logic [W-1:0]       b_load;
  logic               carry_load;
  logic [LIMB_W-1:0]  a_limb, b_limb;
  logic [ADD_W-1:0]   add_y;
  logic               unused_add_hi;
  int                 shamt;

`ifdef BK_SUB_EN
  assign b_load     = sub ? ~op_b : op_b;
  assign carry_load = sub | cin;
`else
  assign b_load     = op_b;
  assign carry_load = cin;
`endif

  assign last = (idx_q == IDX_W'(LIMBS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    accept    = 1'b0;
    step      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        step = 1'b1;
        if (last) state_nxt = ST_DONE;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  bk_limb_shreg #(.LIMBS(LIMBS), .LIMB_W(LIMB_W)) u_sh_a (
    .clk(clk), .rst_n(rst_n), .load(accept), .shift(step), .d(op_a), .limb(a_limb)
  );

  bk_limb_shreg #(.LIMBS(LIMBS), .LIMB_W(LIMB_W)) u_sh_b (
    .clk(clk), .rst_n(rst_n), .load(accept), .shift(step), .d(b_load), .limb(b_limb)
  );

  brent_kung_cin #(.W(LIMB_W)) u_add (
    .a(a_limb), .b(b_limb), .cin(carry_q), .y(add_y)
  );

  assign unused_add_hi = add_y[ADD_W-1];

  // Drop the current limb sum into slot idx, leaving the other limbs alone.
  always_comb begin
    shamt      = int'(idx_q) * LIMB_W;
    limb_mask  = {{(W-LIMB_W){1'b0}}, {LIMB_W{1'b1}}} << shamt;
    limb_ins   = {{(W-LIMB_W){1'b0}}, add_y[LIMB_W-1:0]} << shamt;
    result_nxt = (result_q & ~limb_mask) | limb_ins;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q    <= '0;
      carry_q  <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else if (accept) begin
      idx_q    <= '0;
      carry_q  <= carry_load;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else if (step) begin
      carry_q  <= add_y[LIMB_W];
      result_q <= result_nxt;
      if (last) begin
        cout_q <= add_y[LIMB_W];
        // B limb is already the effective (possibly inverted) operand.
        ovf_q  <= (a_limb[LIMB_W-1] == b_limb[LIMB_W-1]) &&
                  (add_y[LIMB_W-1] != a_limb[LIMB_W-1]);
      end else begin
        idx_q <= idx_q + IDX_W'(1);
      end
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign result    = result_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_bk_chain_seq.sv
// Scoreboard bench for bk_chain_seq: default instance (4x6) plus a LIMBS=2 instance.
module tb_bk_chain_seq;
  import bk_pkg::*;

  localparam int LIMBS  = 4;
  localparam int W      = 24;
  localparam int LIMBS2 = 2;
  localparam int W2     = 12;

  // clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // default instance
  logic          start = 1'b0, cin = 1'b0, sub = 1'b0;
  logic [W-1:0]  op_a = '0, op_b = '0;
  logic          busy, done, cout, ovf;
  logic [W-1:0]  result;
  bk_state_e     state_dbg;

  // LIMBS=2 instance
  logic          s_start = 1'b0, s_cin = 1'b0, s_sub = 1'b0;
  logic [W2-1:0] s_a = '0, s_b = '0;
  logic          s_busy, s_done, s_cout, s_ovf;
  logic [W2-1:0] s_result;
  bk_state_e     s_state;

  bk_chain_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_a(op_a), .op_b(op_b), .cin(cin),
`ifdef BK_SUB_EN
    .sub(sub),
`endif
    .busy(busy), .done(done), .result(result), .cout(cout), .ovf(ovf),
    .state_dbg(state_dbg)
  );

  bk_chain_seq #(.LIMBS(LIMBS2), .LIMB_W(6)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(s_start), .op_a(s_a), .op_b(s_b), .cin(s_cin),
`ifdef BK_SUB_EN
    .sub(s_sub),
`endif
    .busy(s_busy), .done(s_done), .result(s_result), .cout(s_cout), .ovf(s_ovf),
    .state_dbg(s_state)
  );

  // scoreboard queues: {ovf, cout, result} and the cycle done must appear in
  logic [W+1:0]  exp_q[$];
  int            exp_cyc_q[$];
  logic [W2+1:0] exp2_q[$];
  int            exp2_cyc_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain wide arithmetic on w bits; returns {ovf, cout, result[63:0]}.
  function automatic logic [65:0] ref_add(input logic [63:0] a, input logic [63:0] b,
                                          input logic c, input logic s, input int w);
    logic [63:0] mask, a_m, b_eff, res;
    logic [64:0] tot;
    logic        c_eff, co, ov;
    mask  = (64'd1 << w) - 64'd1;
    a_m   = a & mask;
    b_eff = s ? (~b & mask) : (b & mask);
    c_eff = s ? 1'b1 : c;
    tot   = {1'b0, a_m} + {1'b0, b_eff} + {64'd0, c_eff};
    res   = tot[63:0] & mask;
    co    = tot[w];
    ov    = (a_m[w-1] == b_eff[w-1]) && (res[w-1] != a_m[w-1]);
    return {ov, co, res};
  endfunction

  function automatic logic sub_eff(input logic s);
`ifdef BK_SUB_EN
    return s;
`else
    return 1'b0 & s;
`endif
  endfunction

  // driver: default instance
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                       input logic s, output int k);
    logic [65:0] r;
    bit ok;
    ok = 0;
    k  = -1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (!busy) begin ok = 1; break; end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL busy_timeout: got busy=1 after 64 cycles required 0");
      return;
    end
    op_a = a; op_b = b; cin = c; sub = s; start = 1'b1;
    @(posedge clk); #1;
    k = cyc;
    r = ref_add({40'd0, a}, {40'd0, b}, c, sub_eff(s), W);
    exp_q.push_back({r[65], r[64], r[W-1:0]});
    exp_cyc_q.push_back(k + LIMBS);
    // Scramble the inputs: the operation in flight must not see them.
    start = 1'b0;
    op_a = W'($urandom); op_b = W'($urandom);
    cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
  endtask

  // driver: LIMBS=2 instance
  task automatic do_op2(input logic [W2-1:0] a, input logic [W2-1:0] b, input logic c,
                        input logic s);
    logic [65:0] r;
    bit ok;
    ok = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (!s_busy) begin ok = 1; break; end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL busy2_timeout: got busy=1 after 64 cycles required 0");
      return;
    end
    s_a = a; s_b = b; s_cin = c; s_sub = s; s_start = 1'b1;
    @(posedge clk); #1;
    r = ref_add({52'd0, a}, {52'd0, b}, c, sub_eff(s), W2);
    exp2_q.push_back({r[65], r[64], r[W2-1:0]});
    exp2_cyc_q.push_back(cyc + LIMBS2);
    s_start = 1'b0;
    s_a = W2'($urandom); s_b = W2'($urandom); s_cin = 1'($urandom_range(0, 1));
  endtask

  // monitors
  logic          done_d = 1'b0, s_done_d = 1'b0;
  logic [W+1:0]  e1;
  logic [W2+1:0] e2;
  int            ec1, ec2;

  always @(negedge clk) begin
    if (done) begin
      chk("done_single_pulse", {63'd0, done_d}, 64'd0);
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done: got done=1 required no pending operation (cycle %0d)", cyc);
      end else begin
        e1  = exp_q.pop_front();
        ec1 = exp_cyc_q.pop_front();
        chk("result", {40'd0, result}, {40'd0, e1[W-1:0]});
        chk("cout", {63'd0, cout}, {63'd0, e1[W]});
        chk("ovf", {63'd0, ovf}, {63'd0, e1[W+1]});
        chk("done_latency", 64'(cyc), 64'(ec1));
      end
    end
    done_d = done;
  end

  always @(negedge clk) begin
    if (s_done) begin
      if (exp2_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done2: got done=1 required no pending operation (cycle %0d)", cyc);
      end else begin
        e2  = exp2_q.pop_front();
        ec2 = exp2_cyc_q.pop_front();
        chk("result2", {52'd0, s_result}, {52'd0, e2[W2-1:0]});
        chk("cout2", {63'd0, s_cout}, {63'd0, e2[W2]});
        chk("ovf2", {63'd0, s_ovf}, {63'd0, e2[W2+1]});
        chk("done2_latency", 64'(cyc), 64'(ec2));
      end
    end
    s_done_d = s_done;
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
    chk({tag, "_done"}, {63'd0, done}, 64'd0);
    chk({tag, "_result"}, {40'd0, result}, 64'd0);
    chk({tag, "_cout"}, {63'd0, cout}, 64'd0);
    chk({tag, "_ovf"}, {63'd0, ovf}, 64'd0);
    chk({tag, "_state"}, {62'd0, state_dbg}, {62'd0, ST_IDLE});
  endtask

  initial begin
    int k1, k2;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    chk("reset2_result", {52'd0, s_result}, 64'd0);
    chk("reset2_busy", {63'd0, s_busy}, 64'd0);
    rst_n = 1'b1;

    // carry ripple and signed overflow
    do_op(24'hFFFFFF, 24'h000001, 1'b0, 1'b0, k1);
    do_op(24'h7FFFFF, 24'h000001, 1'b0, 1'b0, k1);
    do_op(24'h123456, 24'h654321, 1'b1, 1'b0, k1);
    do_op(24'h800000, 24'h800000, 1'b0, 1'b0, k1);

    // start while busy is ignored; next start on the first IDLE cycle is taken
    do_op(24'h111111, 24'h222222, 1'b0, 1'b0, k1);
    @(negedge clk); @(negedge clk);
    op_a = 24'hFFFFFF; op_b = 24'hFFFFFF; cin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    do_op(24'h0F0F0F, 24'h00F0F1, 1'b0, 1'b0, k2);
    chk("back_to_back_spacing", 64'(k2 - k1), 64'(LIMBS + 2));

    // reset at idx = 2 discards the operation
    do_op(24'h0ABCDE, 24'h135791, 1'b0, 1'b0, k1);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midrun_reset");
    void'(exp_q.pop_back());
    void'(exp_cyc_q.pop_back());
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    do_op(24'h00003F, 24'h000001, 1'b0, 1'b0, k1);

`ifdef BK_SUB_EN
    do_op(24'h000005, 24'h000007, 1'b0, 1'b1, k1);
    do_op(24'h000010, 24'h000003, 1'b0, 1'b1, k1);
`endif

    // randomized traffic
    for (int i = 0; i < 30; i++)
      do_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), k1);

    // LIMBS=2 instance
    do_op2(12'hFFF, 12'h001, 1'b0, 1'b0);
    do_op2(12'h7FF, 12'h001, 1'b0, 1'b0);
    for (int i = 0; i < 15; i++)
      do_op2(W2'($urandom), W2'($urandom), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)));

    for (int i = 0; i < 100; i++) begin
      if (exp_q.size() == 0 && exp2_q.size() == 0) break;
      @(negedge clk);
    end
    chk("drain", 64'(exp_q.size() + exp2_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
